sync_fifo_wr_arb: RTL and testbench
===================================

# sync_fifo_wr_arb

Round-robin write arbiter that shares one `sync_fifo` write port among `NREQ` producers. It sits directly in front of the FIFO and drives its `i_wren`/`i_wrdata`. It grants locked bursts of up to `BURST_MAX` beats per requester and throttles on the FIFO's full and almost-full flags so that no accepted beat is ever dropped.

## Interface
- `DATA_W`, 128: data width; must match the FIFO's `DATA_W`.
- `NREQ`, 4: number of requesters, 2..16.
- `BURST_MAX`, 4: maximum consecutive beats granted to one owner, 1..256.
- `clk`  in  1: clock.
- `rstn`  in  1: asynchronous active-low reset.
- `i_req`  in  NREQ: per-requester valid; bit k belongs to requester k.
- `i_data`  in  NREQ*DATA_W: requester k data is at bits [k*DATA_W +: DATA_W].
- `o_gnt`  out  NREQ: one-hot beat-accept pulse.
- `o_owner`  out  $clog2(NREQ): index of the current or last owner.
- `o_busy`  out  1: a burst lock is held.
- `o_wren`  out  1: to FIFO `i_wren`.
- `o_wrdata`  out  DATA_W: to FIFO `i_wrdata`.
- `i_full`  in  1: from FIFO `o_full`.
- `i_alm_full`  in  1: from FIFO `o_alm_full`; the FIFO's `UPP_TH` must be ≤ DEPTH-2.
- `o_stall_cnt`  out  16: stall counter (see Configuration).

## Operation
**Handshake**
- Requester k holds `i_req[k]` and its data stable until it sees `o_gnt[k]`=1 on a rising edge. On that edge the beat is accepted.
- The requester may present the next beat or drop `i_req` in the following cycle.

**Space check (`ok`, combinational)**
- `ok` = !i_full && (!i_alm_full || !o_wren).
- When almost-full, at most one beat is in flight, so the write rate is at most one beat every 2 cycles.
- Never grant while `i_full` is high.

**FSM**
- IDLE (`o_busy`=0):
  - If `ok` and any `i_req` is set, pick the first set bit at or above `rr_ptr`, wrapping modulo NREQ.
  - Grant it, set owner=k, beat count=1, go to LOCK.
  - If BURST_MAX=1, stay in IDLE and set `rr_ptr`=k+1 mod NREQ.
- LOCK (owner k, `o_busy`=1):
  - If `i_req[k]` and `ok` and count<BURST_MAX: grant k and increment count.
  - If `i_req[k]`=0 or count==BURST_MAX: release the lock and set `rr_ptr`=k+1 mod NREQ. In the same cycle, re-arbitrate as in IDLE, excluding k only when count==BURST_MAX and another request is pending.
  - If `i_req[k]`=1 and !`ok`: hold the lock and do not grant. The count is unchanged.
- `o_gnt` is never asserted when `ok`=0 and is at most one-hot.

**Write pipeline**
- On each grant edge, `o_wren`<=1 and `o_wrdata`<=data of k. Otherwise `o_wren`<=0.
- `o_wrdata` holds its last value when there is no grant.

**Widths**
- Beat count is $clog2(BURST_MAX+1) bits.
- `rr_ptr` wraps from NREQ-1 to 0.

## Timing
- Values on reset (asynchronous, immediate):
  - `o_gnt`=0, `o_wren`=0, `o_wrdata`=0, `o_owner`=0, `o_busy`=0, `o_stall_cnt`=0.
  - `rr_ptr`=0, FSM in IDLE.
- `o_gnt` is combinational from the registered state, `i_req`, `i_full` and `i_alm_full`.
- `o_wren` is registered.
- Latency from grant edge to FIFO write edge is 1 cycle.
- First grant is in the same cycle that `i_req` rises, if `ok`.
- Full throughput is one beat per cycle while `i_alm_full`=0.
- Reset mid-burst: the in-flight `o_wren` is dropped immediately and the lock is lost. The FIFO is reset in the same window.
- A new request from a non-owner during LOCK waits until the lock is released. Worst-case wait is (NREQ-1)*BURST_MAX beats.

## Configuration
- Macro: `SYNC_FIFO_WR_ARB_STATS_EN`.
- **Defined:** `o_stall_cnt` counts cycles in which |`i_req` and `ok`=0.
  - It saturates at 16'hFFFF and is cleared only by reset.
- **Undefined:** `o_stall_cnt` is tied to 0 and no counter flops are inferred.

## Test plan
- NREQ=4, BURST_MAX=4; all requesters assert continuously, FIFO empty -> grants in the sequence 0,0,0,0,1,1,1,1,2,…,3,0; one `o_wren` every cycle; `o_wrdata` matches each requester's beat 1 cycle after its grant.
- Only requester 2 requests, 3 beats, then drops -> `o_gnt`=4'b0100 for 3 cycles; lock released; `rr_ptr`=3; a subsequent request from 1 is granted immediately.
- `i_alm_full`=1, `i_full`=0, requester 0 continuous -> grants every other cycle; `o_wren` pattern 1,0,1,0; no grant while `o_wren`=1.
- `i_full` rises during a burst by owner 1 at count=2 -> no grants and lock held while full; on release of `i_full`, requester 1 gets beats 3 and 4, then the lock rotates to 2.
- `rstn` asserted asynchronously mid-burst with `o_wren`=1 -> `o_wren`, `o_gnt` and `o_busy` go to 0 before the next edge; after release, arbitration restarts at requester 0.
- With `SYNC_FIFO_WR_ARB_STATS_EN`: hold `i_full`=1 with requests pending for 70000 cycles -> `o_stall_cnt`=16'hFFFF. Without the macro -> `o_stall_cnt` reads 0.

Source files
------------

// File: rtl/sync_fifo_wr_arb.sv
// Round-robin, burst-locking write arbiter sharing one sync_fifo write port among NREQ producers.
// Optional stall statistics: define SYNC_FIFO_WR_ARB_STATS_EN.
module sync_fifo_wr_arb #(
    parameter int DATA_W    = 128,
    parameter int NREQ      = 4,
    parameter int BURST_MAX = 4
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [NREQ-1:0]           i_req,
    input  logic [NREQ*DATA_W-1:0]    i_data,
    output logic [NREQ-1:0]           o_gnt,
    output logic [$clog2(NREQ)-1:0]   o_owner,
    output logic                      o_busy,
    output logic                      o_wren,
    output logic [DATA_W-1:0]         o_wrdata,
    input  logic                      i_full,
    input  logic                      i_alm_full,
    output logic [15:0]               o_stall_cnt
);

    localparam int PW = $clog2(NREQ);
    localparam int CW = $clog2(BURST_MAX + 1);

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t          state_r;
    logic [PW-1:0]   owner_r;
    logic [PW-1:0]   rr_ptr_r;
    logic [CW-1:0]   cnt_r;

    logic            ok_s;
    logic            hold_s;
    logic            grant_s;
    logic            pick_hit_s;
    logic [PW-1:0]   pick_idx_s;
    logic [PW-1:0]   gnt_idx_s;
    logic [PW-1:0]   owner_inc_s;
    logic [PW-1:0]   search_base_s;
    logic [DATA_W-1:0] data_arr_s [NREQ];

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] v);
        if (v == PW'(NREQ - 1)) begin
            return {PW{1'b0}};
        end else begin
            return v + PW'(1);
        end
    endfunction

    // First set request at or above base, wrapping; result is {hit, index}.
    function automatic logic [PW:0] rr_pick(input logic [NREQ-1:0] req, input logic [PW-1:0] base);
        logic [PW:0]   res;
        logic [PW:0]   sum;
        logic [PW-1:0] idx;
        res = {(PW+1){1'b0}};
        for (int off = NREQ - 1; off >= 0; off--) begin
            sum = {1'b0, base} + (PW+1)'(off);
            sum = (sum >= (PW+1)'(NREQ)) ? (sum - (PW+1)'(NREQ)) : sum;
            idx = sum[PW-1:0];
            if (req[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Unpack the flat requester data bus.
    always_comb begin
        for (int k = 0; k < NREQ; k++) begin
            data_arr_s[k] = i_data[k*DATA_W +: DATA_W];
        end
    end

    // Space check and grant decision; o_gnt is forced low while reset is asserted.
    always_comb begin
        ok_s          = !i_full && (!i_alm_full || !o_wren);
        owner_inc_s   = wrap_inc(owner_r);
        search_base_s = (state_r == LOCK) ? owner_inc_s : rr_ptr_r;
        {pick_hit_s, pick_idx_s} = rr_pick(i_req, search_base_s);
        hold_s        = (state_r == LOCK) && i_req[owner_r] && (cnt_r < CW'(BURST_MAX));
        if (hold_s) begin
            grant_s   = ok_s;
            gnt_idx_s = owner_r;
        end else begin
            grant_s   = ok_s && pick_hit_s;
            gnt_idx_s = pick_idx_s;
        end
        o_gnt            = {NREQ{1'b0}};
        o_gnt[gnt_idx_s] = grant_s && rstn;
    end

    // Arbitration FSM and registered FIFO write port.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r  <= IDLE;
            owner_r  <= {PW{1'b0}};
            rr_ptr_r <= {PW{1'b0}};
            cnt_r    <= {CW{1'b0}};
            o_wren   <= 1'b0;
            o_wrdata <= {DATA_W{1'b0}};
        end else begin
            o_wren <= grant_s;
            if (grant_s) begin
                o_wrdata <= data_arr_s[gnt_idx_s];
            end
            if (hold_s) begin
                if (ok_s) begin
                    cnt_r <= cnt_r + CW'(1);
                end
            end else begin
                // Releasing a lock advances the pointer past the old owner.
                if (state_r == LOCK) begin
                    rr_ptr_r <= owner_inc_s;
                end
                if (grant_s) begin
                    owner_r <= gnt_idx_s;
                    cnt_r   <= CW'(1);
                    if (BURST_MAX == 1) begin
                        state_r  <= IDLE;
                        rr_ptr_r <= wrap_inc(gnt_idx_s);
                    end else begin
                        state_r <= LOCK;
                    end
                end else begin
                    state_r <= IDLE;
                end
            end
        end
    end

    assign o_owner = owner_r;
    assign o_busy  = (state_r == LOCK);

`ifdef SYNC_FIFO_WR_ARB_STATS_EN
    logic [15:0] stall_r;

    // Saturating count of cycles with pending requests but no space.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_r <= 16'h0000;
        end else if ((|i_req) && !ok_s && (stall_r != 16'hFFFF)) begin
            stall_r <= stall_r + 16'h0001;
        end
    end

    assign o_stall_cnt = stall_r;
`else
    assign o_stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_sync_fifo_wr_arb.sv
// Testbench for sync_fifo_wr_arb: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural arbitration model.
module tb_sync_fifo_wr_arb;

    localparam int DATA_W    = 128;
    localparam int NREQ      = 4;
    localparam int BURST_MAX = 4;

    logic                   clk = 1'b0;
    logic                   rstn;
    logic [NREQ-1:0]        req;
    logic [NREQ*DATA_W-1:0] data;
    logic                   full;
    logic                   alm;
    logic [NREQ-1:0]        gnt;
    logic [1:0]             owner;
    logic                   busy;
    logic                   wren;
    logic [DATA_W-1:0]      wrdata;
    logic [15:0]            stall;

    sync_fifo_wr_arb #(.DATA_W(DATA_W), .NREQ(NREQ), .BURST_MAX(BURST_MAX)) dut (
        .clk(clk), .rstn(rstn), .i_req(req), .i_data(data), .o_gnt(gnt),
        .o_owner(owner), .o_busy(busy), .o_wren(wren), .o_wrdata(wrdata),
        .i_full(full), .i_alm_full(alm), .o_stall_cnt(stall)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural model state (plain integers).
    int                m_locked, m_owner, m_cnt, m_ptr, m_stall;
    logic              m_wren;
    logic [DATA_W-1:0] m_wrdata;
    int                n_locked, n_owner, n_cnt, n_ptr, n_stall;
    logic              n_wren;
    logic [DATA_W-1:0] n_wrdata;
    int                last_g = -1;

    task automatic model_reset();
        m_locked = 0; m_owner = 0; m_cnt = 0; m_ptr = 0; m_stall = 0;
        m_wren = 1'b0; m_wrdata = '0;
        n_locked = 0; n_owner = 0; n_cnt = 0; n_ptr = 0; n_stall = 0;
        n_wren = 1'b0; n_wrdata = '0;
    endtask

    // Compare process: derive expected grant from the arbitration rules and check all outputs.
    always @(negedge clk) begin
        int g;
        bit ok;
        logic [NREQ-1:0] exp_gnt;
        g = -1;
        if (!rstn) begin
            model_reset();
        end else begin
            ok = !full && !(alm && m_wren);
            n_locked = m_locked; n_owner = m_owner; n_cnt = m_cnt; n_ptr = m_ptr; n_stall = m_stall;
            if (m_locked != 0 && req[m_owner] && m_cnt < BURST_MAX) begin
                if (ok) begin
                    g = m_owner;
                    n_cnt = m_cnt + 1;
                end
            end else begin
                if (m_locked != 0) begin
                    n_ptr = (m_owner + 1) % NREQ;
                    n_locked = 0;
                end
                if (ok) begin
                    for (int s = 0; s < NREQ; s++) begin
                        if (g < 0 && req[(n_ptr + s) % NREQ]) g = (n_ptr + s) % NREQ;
                    end
                end
                if (g >= 0) begin
                    n_owner = g;
                    n_cnt = 1;
                    n_locked = (BURST_MAX > 1) ? 1 : 0;
                    if (BURST_MAX == 1) n_ptr = (g + 1) % NREQ;
                end
            end
`ifdef SYNC_FIFO_WR_ARB_STATS_EN
            if ((|req) && !ok && n_stall < 65535) n_stall = n_stall + 1;
`endif
            n_wren = (g >= 0);
            n_wrdata = (g >= 0) ? data[g*DATA_W +: DATA_W] : m_wrdata;
        end
        last_g = g;
        exp_gnt = (g >= 0) ? (4'b0001 << g) : 4'b0000;
        chk("gnt", gnt, exp_gnt);
        chk("busy", busy, m_locked[0]);
        chk("owner", owner, m_owner[1:0]);
        chk("wren", wren, m_wren);
        chk("wrdata", wrdata, m_wrdata);
        chk("stall_cnt", stall, m_stall[15:0]);
    end

    // Model register update.
    always @(posedge clk) begin
        if (!rstn) begin
            model_reset();
        end else begin
            m_locked = n_locked; m_owner = n_owner; m_cnt = n_cnt; m_ptr = n_ptr; m_stall = n_stall;
            m_wren = n_wren; m_wrdata = n_wrdata;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] beat(input int k, input int b);
        return DATA_W'(k * 65536 + b);
    endfunction

    int seq1 [17] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 0};
    logic [DATA_W-1:0] prev_d;

    initial begin
        rstn = 1'b0; req = 4'b1111; full = 1'b0; alm = 1'b0;
        for (int k = 0; k < NREQ; k++) data[k*DATA_W +: DATA_W] = beat(k, 0);
        #2;
        chk("rst_gnt", gnt, 4'b0000);
        chk("rst_wren", wren, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_owner", owner, 2'd0);
        chk("rst_wrdata", wrdata, '0);
        chk("rst_stall", stall, 16'h0000);
        repeat (2) cyc();
        rstn = 1'b1;

        // All requesters continuous: locked bursts of four, rotating.
        prev_d = '0;
        for (int i = 0; i < 17; i++) begin
            #1;
            chk("t1_gnt", gnt, 4'b0001 << seq1[i]);
            if (i > 0) begin
                chk("t1_wren", wren, 1'b1);
                chk("t1_wrdata", wrdata, prev_d);
            end
            prev_d = data[seq1[i]*DATA_W +: DATA_W];
            cyc();
            data[seq1[i]*DATA_W +: DATA_W] = beat(seq1[i], i + 1);
        end
        req = 4'b0000;
        cyc();

        // Only requester 2: three beats, drop, then requester 1 is granted at once.
        req = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t2_gnt", gnt, 4'b0100);
            cyc();
            data[2*DATA_W +: DATA_W] = beat(2, 100 + i);
        end
        req = 4'b0000;
        #1;
        chk("t2_busy_held", busy, 1'b1);
        chk("t2_nogrant", gnt, 4'b0000);
        cyc();
        chk("t2_released", busy, 1'b0);
        req = 4'b0010;
        #1;
        chk("t2_req1_gnt", gnt, 4'b0010);
        cyc();
        req = 4'b0000;
        repeat (2) cyc();

        // Almost-full: one beat every other cycle.
        alm = 1'b1; req = 4'b0001;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("t3_gnt", gnt, (i % 2 == 0) ? 4'b0001 : 4'b0000);
            chk("t3_wren", wren, (i % 2 == 1) ? 1'b1 : 1'b0);
            cyc();
            data[0*DATA_W +: DATA_W] = beat(0, 200 + i);
        end
        alm = 1'b0; req = 4'b0000;
        cyc();

        // Full asserted mid-burst of owner 1 at count 2.
        req = 4'b0110;
        for (int i = 0; i < 7; i++) begin
            full = (i == 2 || i == 3) ? 1'b1 : 1'b0;
            #1;
            if (i == 6) chk("t4_gnt", gnt, 4'b0100);
            else if (i == 2 || i == 3) chk("t4_gnt", gnt, 4'b0000);
            else chk("t4_gnt", gnt, 4'b0010);
            if (i == 2 || i == 3) begin
                chk("t4_busy", busy, 1'b1);
                chk("t4_owner", owner, 2'd1);
            end
            cyc();
            if (i != 2 && i != 3) data[((i == 6) ? 2 : 1)*DATA_W +: DATA_W] = beat(1, 300 + i);
        end
        full = 1'b0; req = 4'b0000;
        repeat (2) cyc();

        // Asynchronous reset mid-burst.
        req = 4'b1111;
        cyc();
        chk("t5_wren_pre", wren, 1'b1);
        #1;
        rstn = 1'b0;
        #1;
        chk("t5_wren_rst", wren, 1'b0);
        chk("t5_gnt_rst", gnt, 4'b0000);
        chk("t5_busy_rst", busy, 1'b0);
        cyc();
        rstn = 1'b1;
        #1;
        chk("t5_restart", gnt, 4'b0001);
        cyc();
        req = 4'b0000;
        repeat (3) cyc();

        // Randomized traffic honoring the hold-until-granted handshake.
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < NREQ; k++) begin
                if (!req[k] || last_g == k) begin
                    req[k] = ($urandom_range(0, 3) != 0);
                    data[k*DATA_W +: DATA_W] = {$urandom, $urandom, $urandom, $urandom};
                end
            end
            full = ($urandom_range(0, 7) == 0);
            alm  = ($urandom_range(0, 3) == 0);
            cyc();
        end

`ifdef SYNC_FIFO_WR_ARB_STATS_EN
        full = 1'b1; req = 4'b1111;
        repeat (70000) cyc();
        #1;
        chk("stall_sat", stall, 16'hFFFF);
`else
        #1;
        chk("stall_off", stall, 16'h0000);
`endif
        full = 1'b0; alm = 1'b0; req = 4'b0000;
        repeat (3) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
